sd_cmd_seq: RTL

SD_CMD_SEQ -- requirements
Module: sd_cmd_seq

---
 rtl/sd_types_pkg.sv | 37 +++
 rtl/sdspi_types_pkg.sv | 14 +
 rtl/sd_crc7.sv | 31 +++
 rtl/sd_cmd_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sd_types_pkg.sv
// sd_types: SD-card level types and constants.
//   sdBYTE_t      : one byte on the SD bus
//   sdCmdState_t  : sequencer states of sd_cmd_seq
//   CRC7_POLY     : x^7 + x^3 + 1, with the x^7 term implied
//   crc7Byte()    : advances a CRC7 by one byte, MSB first
package sd_types;

  typedef logic [7:0] sdBYTE_t;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    CSL  = 4'd1,
    PRE  = 4'd2,
    CMD  = 4'd3,
    POLL = 4'd4,
    RESP = 4'd5,
    POST = 4'd6,
    CSH  = 4'd7,
    DONE = 4'd8
  } sdCmdState_t;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Shift the eight data bits through the CRC register, MSB first.
  function automatic logic [6:0] crc7Byte(input logic [6:0] crcIn, input sdBYTE_t data);
    logic [6:0] c;
    logic       fb;
    c = crcIn;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ CRC7_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/sdspi_types_pkg.sv
// sdspi_types: shared types for the SPI byte engine interface.
//   spiOP_t : operation requested from the byte engine
//             spiNOP = nothing, spiCSL = drive CS low,
//             spiCSH = drive CS high, spiTR = transfer one byte.
package sdspi_types;

  typedef enum logic [1:0] {
    spiNOP = 2'd0,
    spiCSL = 2'd1,
    spiCSH = 2'd2,
    spiTR  = 2'd3
  } spiOP_t;

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: running CRC7 over command bytes.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the CRC at zero
//   update   : fold dataIn into the CRC this cycle
//   dataIn   : byte to fold in
//   crc      : current 7-bit CRC value
module sd_crc7
  import sd_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       update,
  input  sdBYTE_t    dataIn,
  output logic [6:0] crc
);

  // The CRC register: clear has priority so a new command always starts
  // from zero, then each update folds in a whole byte in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= 7'd0;
    end else if (clear) begin
      crc <= 7'd0;
    end else if (update) begin
      crc <= crc7Byte(crc, dataIn);
    end
  end

endmodule

// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: SD SPI-mode command sequencer.
// Drives a byte engine to send one command frame and collect its response:
// CS low, one 0xFF, 6 command bytes with CRC7, R1 polling (up to POLL_MAX),
// optional 4 trailing response bytes, one 0xFF, then CS high unless the
// caller keeps CS asserted for a following data phase.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   cmdSTART/IDX/ARG/RLEN/KEEPCS    : command request and parameters
//   cmdBUSY, cmdDONE                : handshake back to the requester
//   cmdR1, cmdRESP, cmdTMO          : results, held until the next start
//   spiOP, spiTXD                   : requests to the byte engine
//   spiRXD, spiDONE                 : byte engine results
module sd_cmd_seq
  import sdspi_types::*;
  import sd_types::*;
#(
  parameter int POLL_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmdSTART,
  input  logic [5:0]  cmdIDX,
  input  logic [31:0] cmdARG,
  input  logic        cmdRLEN,
  input  logic        cmdKEEPCS,
  output logic        cmdBUSY,
  output logic        cmdDONE,
  output sdBYTE_t     cmdR1,
  output logic [31:0] cmdRESP,
  output logic        cmdTMO,
  output spiOP_t      spiOP,
  output sdBYTE_t     spiTXD,
  input  sdBYTE_t     spiRXD,
  input  logic        spiDONE
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);

  sdCmdState_t   state;
  logic          waitDone;
  logic [2:0]    byteCnt;
  logic [PW-1:0] pollCnt;
  logic [5:0]    idxReg;
  logic [31:0]   argReg;
  logic          rlenReg;
  logic          keepCsReg;
  logic          crcClear;
  logic          crcUpdate;
  logic [6:0]    crcOut;
  sdBYTE_t       cmdByte;

  // Select the command frame byte for the current byte position. The CRC
  // byte reads the CRC register, which has absorbed bytes 0..4 by the time
  // byte 5 is issued because each byte is folded in as it is sent.
  always_comb begin
    cmdByte = 8'hFF;
    case (byteCnt)
      3'd0:    cmdByte = {2'b01, idxReg};
      3'd1:    cmdByte = argReg[31:24];
      3'd2:    cmdByte = argReg[23:16];
      3'd3:    cmdByte = argReg[15:8];
      3'd4:    cmdByte = argReg[7:0];
      3'd5:    cmdByte = {crcOut, 1'b1};
      default: cmdByte = 8'hFF;
    endcase
  end

  // The CRC restarts on an accepted command and absorbs each of the first
  // five frame bytes in the cycle that byte is handed to the byte engine.
  always_comb begin
    crcClear  = (state == IDLE) && cmdSTART && !cmdBUSY;
    crcUpdate = (state == CMD) && !waitDone && (byteCnt != 3'd5);
  end

  sd_crc7 uCrc (
    .clk    (clk),
    .rst    (rst),
    .clear  (crcClear),
    .update (crcUpdate),
    .dataIn (cmdByte),
    .crc    (crcOut)
  );

  // Sequencer. spiOP defaults to NOP every cycle so that every operation is
  // a single-cycle pulse. All byte states share one handshake: issue spiTR
  // once, then sit with waitDone set until spiDONE, and only then decide
  // where to go. Because the decision is registered, the next spiTR can
  // appear no earlier than the cycle after spiDONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitDone  <= 1'b0;
      byteCnt   <= 3'd0;
      pollCnt   <= '0;
      idxReg    <= 6'd0;
      argReg    <= 32'd0;
      rlenReg   <= 1'b0;
      keepCsReg <= 1'b0;
      spiOP     <= spiNOP;
      spiTXD    <= 8'hFF;
      cmdBUSY   <= 1'b0;
      cmdDONE   <= 1'b0;
      cmdR1     <= 8'hFF;
      cmdRESP   <= 32'd0;
      cmdTMO    <= 1'b0;
    end else begin
      spiOP <= spiNOP;
      case (state)
        IDLE: begin
          cmdDONE <= 1'b0;
          // cmdBUSY is still high during the cmdDONE cycle, which keeps a
          // start in that cycle from being taken.
          if (cmdSTART && !cmdBUSY) begin
            idxReg    <= cmdIDX;
            argReg    <= cmdARG;
            rlenReg   <= cmdRLEN;
            keepCsReg <= cmdKEEPCS;
            cmdBUSY   <= 1'b1;
            cmdTMO    <= 1'b0;
            cmdRESP   <= 32'd0;
            byteCnt   <= 3'd0;
            pollCnt   <= '0;
            state     <= CSL;
          end else begin
            cmdBUSY <= 1'b0;
          end
        end
        CSL: begin
          spiOP <= spiCSL;
          state <= PRE;
        end
        PRE, CMD, POLL, RESP, POST: begin
          if (!waitDone) begin
            spiOP    <= spiTR;
            spiTXD   <= (state == CMD) ? cmdByte : 8'hFF;
            waitDone <= 1'b1;
            if (state == POLL) pollCnt <= pollCnt + 1'b1;
          end else if (spiDONE) begin
            waitDone <= 1'b0;
            spiTXD   <= 8'hFF;
            case (state)
              PRE: begin
                byteCnt <= 3'd0;
                state   <= CMD;
              end
              CMD: begin
                if (byteCnt == 3'd5) begin
                  byteCnt <= 3'd0;
                  state   <= POLL;
                end else begin
                  byteCnt <= byteCnt + 3'd1;
                end
              end
              POLL: begin
                // pollCnt already counts the byte just received, so the
                // POLL_MAX-th byte is still examined before timing out.
                if (!spiRXD[7]) begin
                  cmdR1 <= spiRXD;
                  state <= rlenReg ? RESP : POST;
                end else if (pollCnt == POLL_LAST) begin
                  cmdTMO <= 1'b1;
                  cmdR1  <= 8'hFF;
                  state  <= POST;
                end
              end
              RESP: begin
                cmdRESP <= {cmdRESP[23:0], spiRXD};
                if (byteCnt == 3'd3) begin
                  byteCnt <= 3'd0;
                  state   <= POST;
                end else begin
                  byteCnt <= byteCnt + 3'd1;
                end
              end
              default: state <= CSH;
            endcase
          end
        end
        CSH: begin
          // A timeout always releases CS; the caller's keep request only
          // applies when a data phase can actually follow.
          if (!keepCsReg || cmdTMO) spiOP <= spiCSH;
          state <= DONE;
        end
        DONE: begin
          cmdDONE <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
